// File: rtl/hazard_controller_if.sv
// Decode-stage hazard bus: decode fields into the hazard controller, pipeline
// stall/flush and forwarding selects back out.
interface hazard_controller_if;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  WriteRegD;
  logic        RegWriteD;
  logic        MemtoRegD;
  logic        BranchD;
  logic        JumpD;
  logic        PCSrcD;
  logic        StallF;
  logic        StallD;
  logic        FlushE;
  logic        FlushD;
  logic        ForwardAD;
  logic        ForwardBD;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [15:0] StallCount;

  // Pipeline side: drives decode fields, consumes hazard controls
  modport master (
    output RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, JumpD, PCSrcD,
    input  StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallCount
  );

  // Hazard controller side
  modport slave (
    input  RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, JumpD, PCSrcD,
    output StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller. Tracks the instructions in E, M and W
// in a small scoreboard and derives stalls, flushes and forwarding selects
// combinationally from that scoreboard and the instruction sitting in decode.
module hazard_controller #(
  // Saturation ceiling of the stall counter; full 16-bit range by default
  parameter logic [15:0] StallCountMax = 16'hFFFF
) (
  input logic                clkH,
  input logic                rstH,
  hazard_controller_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memtoreg;
  } entry_t;

  entry_t      r_e, r_m, r_w;
  entry_t      w_dec;
  logic [15:0] r_stall_count;

  logic w_e_rw, w_e_mt, w_m_rw, w_m_mt, w_w_rw;
  logic w_e_hit_d, w_m_hit_d;
  logic w_lwstall, w_branchstall, w_stall;

  // Decode instruction as it would enter E
  always_comb begin
    w_dec          = '0;
    w_dec.valid    = 1'b1;
    w_dec.rs       = hz.RsD;
    w_dec.rt       = hz.RtD;
    w_dec.dst      = hz.WriteRegD;
    w_dec.regwrite = hz.RegWriteD;
    w_dec.memtoreg = hz.MemtoRegD;
  end

  // Qualified scoreboard flags; a write to $0 is never a real producer
  always_comb begin
    w_e_rw    = r_e.valid & r_e.regwrite & (r_e.dst != 5'd0);
    w_e_mt    = r_e.valid & r_e.memtoreg & (r_e.dst != 5'd0);
    w_m_rw    = r_m.valid & r_m.regwrite & (r_m.dst != 5'd0);
    w_m_mt    = r_m.valid & r_m.memtoreg & (r_m.dst != 5'd0);
    w_w_rw    = r_w.valid & r_w.regwrite & (r_w.dst != 5'd0);
    w_e_hit_d = (r_e.dst == hz.RsD) | (r_e.dst == hz.RtD);
    w_m_hit_d = (r_m.dst == hz.RsD) | (r_m.dst == hz.RtD);
  end

  // Stall detection: load-use, and branch operands not yet available in decode
  always_comb begin
    w_lwstall     = w_e_mt & w_e_rw & w_e_hit_d;
    w_branchstall = hz.BranchD & ((w_e_rw & w_e_hit_d) | (w_m_mt & w_m_hit_d));
    w_stall       = ~rstH & (w_lwstall | w_branchstall);
  end

  // Output decode; everything is held at zero while reset is asserted
  always_comb begin
    hz.StallF     = w_stall;
    hz.StallD     = w_stall;
    hz.FlushE     = w_stall;
    hz.FlushD     = 1'b0;
    hz.ForwardAD  = 1'b0;
    hz.ForwardBD  = 1'b0;
    hz.ForwardAE  = 2'b00;
    hz.ForwardBE  = 2'b00;
    hz.StallCount = 16'd0;
    if (!rstH) begin
      // A stall holds the redirecting instruction; it flushes once released
      hz.FlushD     = (hz.PCSrcD | hz.JumpD) & ~w_stall;
      hz.ForwardAD  = (hz.RsD != 5'd0) & w_m_rw & (r_m.dst == hz.RsD);
      hz.ForwardBD  = (hz.RtD != 5'd0) & w_m_rw & (r_m.dst == hz.RtD);
      hz.StallCount = r_stall_count;
      // M-stage result is newer than W, so it wins
      if ((r_e.rs != 5'd0) && w_m_rw && (r_m.dst == r_e.rs)) begin
        hz.ForwardAE = 2'b10;
      end else if ((r_e.rs != 5'd0) && w_w_rw && (r_w.dst == r_e.rs)) begin
        hz.ForwardAE = 2'b01;
      end
      if ((r_e.rt != 5'd0) && w_m_rw && (r_m.dst == r_e.rt)) begin
        hz.ForwardBE = 2'b10;
      end else if ((r_e.rt != 5'd0) && w_w_rw && (r_w.dst == r_e.rt)) begin
        hz.ForwardBE = 2'b01;
      end
    end
  end

  // Scoreboard shift (bubble into E on stall) and saturating stall counter
  always_ff @(posedge clkH) begin
    if (rstH) begin
      r_e           <= '0;
      r_m           <= '0;
      r_w           <= '0;
      r_stall_count <= 16'd0;
    end else begin
      r_w <= r_m;
      r_m <= r_e;
      r_e <= w_stall ? entry_t'('0) : w_dec;
      if (w_stall && (r_stall_count < StallCountMax)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: each vector drives one decode cycle and
// queues the outputs expected for that cycle; a monitor pops and compares.
module tb_hazard_controller;

  localparam logic [15:0] SatMax = 16'd12;

  logic clkH = 1'b0;
  logic rstH = 1'b1;

  hazard_controller_if hz ();

  hazard_controller #(.StallCountMax(SatMax)) dut (
    .clkH (clkH),
    .rstH (rstH),
    .hz   (hz)
  );

  always #5 clkH = ~clkH;

  typedef struct {
    string       name;
    logic [25:0] exp;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [25:0] m_act;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Drive one decode cycle and queue its expected outputs
  // exp packing: {StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD, ForwardAE, ForwardBE, cnt}
  task automatic vec(input string nm, input int r, input int rs, input int rt, input int dst,
                     input int rw, input int mt, input int br, input int jp, input int pc,
                     input int st, input int fd, input int fad, input int fbd,
                     input int fae, input int fbe, input int cnt);
    exp_t e;
    @(posedge clkH);
    #1;
    rstH         = 1'(r);
    hz.RsD       = 5'(rs);
    hz.RtD       = 5'(rt);
    hz.WriteRegD = 5'(dst);
    hz.RegWriteD = 1'(rw);
    hz.MemtoRegD = 1'(mt);
    hz.BranchD   = 1'(br);
    hz.JumpD     = 1'(jp);
    hz.PCSrcD    = 1'(pc);
    e.name = nm;
    e.exp  = {1'(st), 1'(st), 1'(st), 1'(fd), 1'(fad), 1'(fbd), 2'(fae), 2'(fbe), 16'(cnt)};
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; sample mid-cycle
  always @(negedge clkH) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.ForwardAD, hz.ForwardBD,
               hz.ForwardAE, hz.ForwardBE, hz.StallCount};
      n_checks++;
      if (m_act === m_e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got sF/sD/fE/fD=%b fAD/fBD=%b fAE=%b fBE=%b cnt=%0d, want %b %b %b %b cnt=%0d",
                 m_e.name, m_act[25:22], m_act[21:20], m_act[19:18], m_act[17:16], m_act[15:0],
                 m_e.exp[25:22], m_e.exp[21:20], m_e.exp[19:18], m_e.exp[17:16], m_e.exp[15:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hz.RsD = '0; hz.RtD = '0; hz.WriteRegD = '0; hz.RegWriteD = 1'b0;
    hz.MemtoRegD = 1'b0; hz.BranchD = 1'b0; hz.JumpD = 1'b0; hz.PCSrcD = 1'b0;
    //   name            rst rs rt dst rw mt br j pc | st fd fad fbd fae fbe cnt
    vec("reset0",         1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("reset1",         1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    // Load-use
    vec("lw_r8",          0, 2, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("lu_stall",       0, 8, 3,10, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vec("lu_release",     0, 8, 3,10, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    vec("lu_fwd_w",       0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1);
    // ALU-ALU
    vec("alu_prod",       0, 1, 2, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec("alu_cons",       0, 5, 5, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec("alu_fwd_m",      0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 2, 1);
    // Double hazard, M beats W
    vec("dbl_add3",       0, 1, 2, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec("dbl_or3",        0, 4, 4, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec("dbl_and",        0, 3, 7,11, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    vec("dbl_m_prio",     0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 0, 1);
    // ALU result feeding a taken branch
    vec("br_add9",        0, 1, 2, 9, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec("br_stall",       0, 9, 0, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 1);
    vec("br_release",     0, 9, 0, 0, 0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0, 2);
    vec("br_after",       0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2);
    // Load feeding a branch: two stall cycles
    vec("lwbr_lw9",       0, 1, 0, 9, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vec("lwbr_stall1",    0, 4, 9, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    vec("lwbr_stall2",    0, 4, 9, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0, 0, 3);
    vec("lwbr_release",   0, 4, 9, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 4);
    // Register 0 never matches
    vec("r0_lw",          0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
    vec("r0_beq",         0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 4);
    vec("jump",           0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 4);
    // Jump coinciding with a load-use stall, then reset mid-stall
    vec("j_lw8",          0, 1, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
    vec("j_stall_wins",   0, 8, 0, 2, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 4);
    vec("j_flush_after",  0, 8, 0, 2, 1, 0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 5);
    vec("rst_lw7",        0, 1, 0, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 5);
    vec("rst_stall",      0, 7, 0, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 5);
    vec("rst_mid_stall",  1, 7, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    vec("rst_empty",      0, 7, 0, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0);
    vec("rst_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    // Repeated self-dependent loads: one stall every other cycle until saturation
    vec("sat_first",      0, 8, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("sat_stall0",     0, 8, 0, 8, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      int c;
      c = (k < int'(SatMax)) ? k : int'(SatMax);
      vec($sformatf("sat_free%0d", k),  0, 8, 0, 8, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, c);
      vec($sformatf("sat_stall%0d", k), 0, 8, 0, 8, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, c);
    end
    vec("sat_hold",       0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, int'(SatMax));
    // Drain the scoreboard queue with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clkH);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clkH  input  1  clock; all state updates on rising edge.
REQ-003 rstH  input  1  synchronous active-high reset.
REQ-004 RsD, RtD  input  5 each  source register fields of the instruction in decode.
REQ-005 WriteRegD  input  5  destination register of the decode instruction (post RegDst selection).
REQ-006 RegWriteD, MemtoRegD, BranchD, JumpD  input  1 each  decode control bits.
REQ-007 PCSrcD  input  1  branch taken, resolved in decode.
REQ-008 StallF, StallD, FlushE, FlushD  output  1 each  pipeline register controls.
REQ-009 ForwardAD, ForwardBD  output  1 each  select the M-stage ALU result onto the decode comparator operands.
REQ-010 ForwardAE, ForwardBE  output  2 each  execute operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-011 StallCount  output  16  saturating count of cycles with StallD=1.

Function
REQ-012 The block SHALL keep an internal scoreboard of three entries: E, M, W. Each entry holds {valid, rs, rt, dst, regwrite, memtoreg}.
REQ-013 Each rising edge without reset SHALL shift W<=M and M<=E.
REQ-014 On the same edge, E SHALL load the decode fields if FlushE=0; otherwise E SHALL load a bubble (valid=0, regwrite=0, memtoreg=0).
REQ-015 Entry regwrite/memtoreg SHALL be qualified by valid. A dst of 0 SHALL never match any source.
REQ-016 lwstall = E.memtoreg & E.regwrite & (E.dst==RsD | E.dst==RtD).
REQ-017 branchstall = BranchD & ((E.regwrite & E.dst∈{RsD,RtD}) | (M.memtoreg & M.dst∈{RsD,RtD})).
REQ-018 StallF = StallD = FlushE = lwstall | branchstall. These outputs are combinational (zero-cycle) from the scoreboard and the decode inputs.
REQ-019 FlushD = (PCSrcD | JumpD) & ~StallD.
REQ-020 ForwardAD = (RsD!=0) & M.regwrite & (M.dst==RsD). ForwardBD is the same using RtD.
REQ-021 ForwardAE SHALL be 10 if E.rs!=0 & M.regwrite & M.dst==E.rs.
REQ-022 Otherwise ForwardAE SHALL be 01 if E.rs!=0 & W.regwrite & W.dst==E.rs.
REQ-023 Otherwise ForwardAE SHALL be 00. ForwardBE follows the same rules using E.rt.
REQ-024 The M-stage match SHALL take priority over the W-stage match when both match.
REQ-025 StallCount SHALL increment by 1 on each edge where StallD=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 When PCSrcD or JumpD coincides with a stall, the stall SHALL win: FlushD=0 and the decode instruction is held. FlushD asserts on the first non-stalled cycle.
REQ-027 A stalled decode instruction SHALL re-evaluate every cycle. A load-use stall SHALL last exactly 1 cycle. A branch stall SHALL last at most 2 cycles.

Reset
REQ-028 On a rising edge with rstH=1, all scoreboard valid bits SHALL clear, all stored fields SHALL go to 0, and StallCount SHALL go to 0.
REQ-029 While rstH=1, all outputs SHALL be driven 0: StallF/StallD/FlushE/FlushD=0, ForwardAD/BD=0, ForwardAE/BE=00.
REQ-030 Reset asserted mid-stall SHALL abort the stall. The first cycle after reset SHALL see an empty scoreboard.

Verification
REQ-031 Load-use: lw $8 in D, next cycle add with RsD=8 -> one cycle of StallF=StallD=FlushE=1, StallCount=1. On the next cycle ForwardAE=01.
REQ-032 ALU-ALU: add with dst=5, then sub with RsD=5, RtD=5 -> no stall. In E, ForwardAE=ForwardBE=10.
REQ-033 Double hazard: add dst=3, then or dst=3, then and RsD=3 -> ForwardAE=10 (M priority over W).
REQ-034 Branch: add dst=9 immediately before beq RsD=9 -> 1 stall cycle, then ForwardAD=1. If PCSrcD=1, FlushD=1 only after the stall releases.
REQ-035 Branch after lw: lw dst=9 then beq RtD=9 -> 2 stall cycles, StallCount=2. Register 0 case: dst=0, RsD=0 -> no stall, no forward.
REQ-036 Reset mid-stall, plus saturation: assert rstH during a load-use stall -> all outputs 0 and StallCount=0 on the next cycle. Forcing 70000 stall cycles -> StallCount holds 16'hFFFF.
